// File: rtl/nec_pkg.sv
// Shared types and helpers for the NEC IR frame checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package nec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        OUT     = 2'd3
    } nec_state_e;

    // MSB position of each received byte inside the raw 32-bit frame.
    // The first byte on the air lands in bits 31:24, LSB first.
    localparam int B0_MSB = 31;
    localparam int B1_MSB = 23;
    localparam int B2_MSB = 15;
    localparam int B3_MSB = 7;

    // 110 ms at 20 MHz.
    localparam int unsigned DEFAULT_REPEAT_WINDOW = 32'd2200000;

    // NEC sends each byte LSB first, while the decoder shifts MSB first.
    function automatic logic [7:0] rev_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/nec_frame_checker_if.sv
// Bundles the decoder-side inputs and the host-side command record.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake on the command record.
interface nec_frame_checker_if #(
    parameter int RPT_CNT_W = 8
);
    logic [31:0]          frame_data;
    logic                 frame_valid;
    logic                 repeat_seen;
    logic                 cmd_ready;
    logic                 ovr_clr;
    logic                 cmd_valid;
    logic [15:0]          cmd_addr;
    logic [7:0]           cmd_code;
    logic                 cmd_repeat;
    logic [RPT_CNT_W-1:0] rpt_count;
    logic                 err_addr;
    logic                 err_cmd;
    logic                 overrun;

    // Decoder / host side.
    modport master (
        output frame_data, frame_valid, repeat_seen, cmd_ready, ovr_clr,
        input  cmd_valid, cmd_addr, cmd_code, cmd_repeat, rpt_count,
               err_addr, err_cmd, overrun
    );

    // Frame checker side.
    modport slave (
        input  frame_data, frame_valid, repeat_seen, cmd_ready, ovr_clr,
        output cmd_valid, cmd_addr, cmd_code, cmd_repeat, rpt_count,
               err_addr, err_cmd, overrun
    );
endinterface

// File: rtl/nec_repeat_timer.sv
// Repeat-code window: loadable down-counter, open while non-zero.
// Latency: load takes effect the cycle after load_i; open_o is registered.
// Backpressure: none.
// Ports: clkin/rst (sync, active high), load_i (reload to WINDOW), open_o.
module nec_repeat_timer #(
    parameter int unsigned WINDOW = 32'd2200000
) (
    input  logic clkin,
    input  logic rst,
    input  logic load_i,
    output logic open_o
);
    localparam int CNT_W = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clkin) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CNT_W'(WINDOW);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign open_o = (count_q != '0);
endmodule

// File: rtl/nec_frame_checker.sv
// Checks raw NEC frames, tracks repeat codes and presents validated commands.
// Latency: frame_valid at N -> cmd_valid at N+2; repeat_seen at N -> cmd_valid at N+1.
// Backpressure: single-entry output; input arriving outside IDLE/handshake is dropped and sets overrun.
// Ports: clkin, rst (sync, active high); bus carries frame_data/frame_valid/repeat_seen/
// ovr_clr in, cmd_valid/cmd_ready handshake with cmd_addr/cmd_code/cmd_repeat/rpt_count,
// and err_addr/err_cmd pulses plus the sticky overrun flag out.
module nec_frame_checker
    import nec_pkg::*;
#(
    parameter bit          EXT_ADDR_EN   = 1'b0,
    parameter int unsigned REPEAT_WINDOW = DEFAULT_REPEAT_WINDOW,
    parameter int          RPT_CNT_W     = 8
) (
    input  logic                clkin,
    input  logic                rst,
    nec_frame_checker_if.slave  bus
);
    nec_state_e           state_q, state_d;
    logic [31:0]          frame_q, frame_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [15:0]          cmd_addr_q, cmd_addr_d;
    logic [7:0]           cmd_code_q, cmd_code_d;
    logic                 cmd_repeat_q, cmd_repeat_d;
    logic [RPT_CNT_W-1:0] rpt_q, rpt_d;
    logic                 err_addr_q, err_addr_d;
    logic                 err_cmd_q, err_cmd_d;
    logic                 ovr_q, ovr_d;
    logic [15:0]          last_addr_q, last_addr_d;
    logic [7:0]           last_code_q, last_code_d;

    logic       win_load, win_open;
    logic [7:0] b0, b1, b2, b3;
    logic       addr_ok, cmd_ok;
    logic [15:0] frame_addr;
    logic       hs, can_take, take_frame, take_rpt, dropped;

    nec_repeat_timer #(.WINDOW(REPEAT_WINDOW)) u_timer (
        .clkin  (clkin),
        .rst    (rst),
        .load_i (win_load),
        .open_o (win_open)
    );

    assign b0 = rev_byte(frame_q[B0_MSB -: 8]);
    assign b1 = rev_byte(frame_q[B1_MSB -: 8]);
    assign b2 = rev_byte(frame_q[B2_MSB -: 8]);
    assign b3 = rev_byte(frame_q[B3_MSB -: 8]);

    // Extended NEC reuses B1 as the address high byte, so there is nothing to check.
    assign addr_ok    = EXT_ADDR_EN ? 1'b1 : (b1 == ~b0);
    assign cmd_ok     = (b3 == ~b2);
    assign frame_addr = EXT_ADDR_EN ? {b1, b0} : {8'h00, b0};

    // The handshake cycle frees the output slot, so it may take new input too.
    assign hs         = cmd_valid_q && bus.cmd_ready;
    assign can_take   = (state_q == IDLE) || hs;
    assign take_frame = can_take && bus.frame_valid;
    assign take_rpt   = can_take && !bus.frame_valid && bus.repeat_seen && win_open;
    assign dropped    = !can_take && (bus.frame_valid || bus.repeat_seen);

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_code_d   = cmd_code_q;
        cmd_repeat_d = cmd_repeat_q;
        rpt_d        = rpt_q;
        err_addr_d   = 1'b0;
        err_cmd_d    = 1'b0;
        ovr_d        = ovr_q;
        last_addr_d  = last_addr_q;
        last_code_d  = last_code_q;
        win_load     = 1'b0;

        case (state_q)
            IDLE: ;
            CAPTURE: begin
                // Comparison results are registered so CHECK sees them as
                // the error pulses / valid output in the same cycle.
                state_d    = CHECK;
                err_addr_d = !addr_ok;
                err_cmd_d  = !cmd_ok;
                if (addr_ok && cmd_ok) begin
                    cmd_valid_d  = 1'b1;
                    cmd_addr_d   = frame_addr;
                    cmd_code_d   = b2;
                    cmd_repeat_d = 1'b0;
                    rpt_d        = '0;
                    last_addr_d  = frame_addr;
                    last_code_d  = b2;
                    win_load     = 1'b1;
                end
            end
            CHECK:   state_d = cmd_valid_q ? OUT : IDLE;
            OUT:     ;
            default: state_d = IDLE;
        endcase

        if (hs) begin
            cmd_valid_d = 1'b0;
            state_d     = IDLE;
        end

        if (take_frame) begin
            frame_d = bus.frame_data;
            state_d = CAPTURE;
        end else if (take_rpt) begin
            state_d      = OUT;
            cmd_valid_d  = 1'b1;
            cmd_addr_d   = last_addr_q;
            cmd_code_d   = last_code_q;
            cmd_repeat_d = 1'b1;
            rpt_d        = (&rpt_q) ? rpt_q : rpt_q + RPT_CNT_W'(1);
            win_load     = 1'b1;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (dropped) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_code_q   <= '0;
            cmd_repeat_q <= 1'b0;
            rpt_q        <= '0;
            err_addr_q   <= 1'b0;
            err_cmd_q    <= 1'b0;
            ovr_q        <= 1'b0;
            last_addr_q  <= '0;
            last_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_code_q   <= cmd_code_d;
            cmd_repeat_q <= cmd_repeat_d;
            rpt_q        <= rpt_d;
            err_addr_q   <= err_addr_d;
            err_cmd_q    <= err_cmd_d;
            ovr_q        <= ovr_d;
            last_addr_q  <= last_addr_d;
            last_code_q  <= last_code_d;
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.cmd_code   = cmd_code_q;
    assign bus.cmd_repeat = cmd_repeat_q;
    assign bus.rpt_count  = rpt_q;
    assign bus.err_addr   = err_addr_q;
    assign bus.err_cmd    = err_cmd_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_nec_frame_checker.sv
// Directed bench for nec_frame_checker (standard and extended address builds).
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge.
// Backpressure: cmd_ready is driven directly by the sequence below.
module tb_nec_frame_checker;
    localparam int unsigned W = 40;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nec_frame_checker_if #(.RPT_CNT_W(8)) bus ();
    nec_frame_checker_if #(.RPT_CNT_W(8)) bx ();

    nec_frame_checker #(.EXT_ADDR_EN(1'b0), .REPEAT_WINDOW(W), .RPT_CNT_W(8)) dut (
        .clkin (clk),
        .rst   (rst),
        .bus   (bus)
    );

    nec_frame_checker #(.EXT_ADDR_EN(1'b1), .REPEAT_WINDOW(W), .RPT_CNT_W(8)) dut_x (
        .clkin (clk),
        .rst   (rst),
        .bus   (bx)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [31:0] d);
        bus.frame_data  = d;
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
    endtask

    task automatic send_rpt();
        bus.repeat_seen = 1'b1;
        tick();
        bus.repeat_seen = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_data = '0; bus.frame_valid = 0; bus.repeat_seen = 0;
        bus.cmd_ready = 1'b1; bus.ovr_clr = 0;
        bx.frame_data = '0; bx.frame_valid = 0; bx.repeat_seen = 0;
        bx.cmd_ready = 1'b1; bx.ovr_clr = 0;
        tick(2);
        chk("rst_valid",  bus.cmd_valid, 0);
        chk("rst_addr",   bus.cmd_addr, 0);
        chk("rst_code",   bus.cmd_code, 0);
        chk("rst_repeat", bus.cmd_repeat, 0);
        chk("rst_rpt",    bus.rpt_count, 0);
        chk("rst_err",    {bus.err_addr, bus.err_cmd}, 0);
        chk("rst_ovr",    bus.overrun, 0);
        rst = 1'b0;
        tick();

        // Bad command inverse, no good frame yet.
        send_frame(32'h20DF10EE);
        chk("bad_c1_err", bus.err_cmd, 0);
        tick();
        chk("bad_err_cmd",  bus.err_cmd, 1);
        chk("bad_err_addr", bus.err_addr, 0);
        chk("bad_valid",    bus.cmd_valid, 0);
        tick();
        chk("bad_err_once", bus.err_cmd, 0);
        send_rpt();
        chk("rpt_nogood_valid", bus.cmd_valid, 0);
        chk("rpt_nogood_ovr",   bus.overrun, 0);
        tick(2);

        // Good frame: accept edge A is the one just before the c2 sample.
        send_frame(32'h20DF10EF);
        chk("good_c1_valid", bus.cmd_valid, 0);
        tick();
        chk("good_valid",  bus.cmd_valid, 1);
        chk("good_addr",   bus.cmd_addr, 16'h0004);
        chk("good_code",   bus.cmd_code, 8'h08);
        chk("good_repeat", bus.cmd_repeat, 0);
        chk("good_err",    {bus.err_addr, bus.err_cmd}, 0);
        tick();
        chk("good_hs_done", bus.cmd_valid, 0);
        tick(18);
        send_rpt();                         // sampled at A+20
        chk("rpt_valid",  bus.cmd_valid, 1);
        chk("rpt_repeat", bus.cmd_repeat, 1);
        chk("rpt_addr",   bus.cmd_addr, 16'h0004);
        chk("rpt_code",   bus.cmd_code, 8'h08);
        chk("rpt_count1", bus.rpt_count, 1);
        tick(W - 1);
        send_rpt();                         // exactly W after the last repeat
        chk("rpt_edge_valid", bus.cmd_valid, 1);
        chk("rpt_count2",     bus.rpt_count, 2);
        tick(W);
        send_rpt();                         // W+1 after the last repeat
        chk("rpt_late_valid", bus.cmd_valid, 0);
        chk("rpt_late_count", bus.rpt_count, 2);
        chk("rpt_late_ovr",   bus.overrun, 0);
        tick();

        // Second pattern, then a double failure that must not disturb last-good.
        send_frame(32'h807FA25D);
        tick();
        chk("p2_addr",  bus.cmd_addr, 16'h0001);
        chk("p2_code",  bus.cmd_code, 8'h45);
        chk("p2_count", bus.rpt_count, 0);
        tick();
        send_frame(32'h20DE10EE);
        tick();
        chk("both_err", {bus.err_addr, bus.err_cmd}, 2'b11);
        chk("both_valid", bus.cmd_valid, 0);
        tick();
        send_rpt();
        chk("rpt_after_bad_addr", bus.cmd_addr, 16'h0001);
        chk("rpt_after_bad_code", bus.cmd_code, 8'h45);
        chk("rpt_after_bad_cnt",  bus.rpt_count, 1);
        tick();

        // Frame and repeat together in IDLE: frame wins, no overrun.
        bus.repeat_seen = 1'b1;
        send_frame(32'h20DF10EF);
        bus.repeat_seen = 1'b0;
        chk("both_in_ovr", bus.overrun, 0);
        tick();
        chk("both_in_repeat", bus.cmd_repeat, 0);
        chk("both_in_addr",   bus.cmd_addr, 16'h0004);
        tick();

        // Extended address on one build, same frame on the standard build.
        bx.frame_data = 32'h20DE10EF; bx.frame_valid = 1'b1;
        bus.frame_data = 32'h20DE10EF; bus.frame_valid = 1'b1;
        tick();
        bx.frame_valid = 1'b0; bus.frame_valid = 1'b0;
        tick();
        chk("ext_valid",    bx.cmd_valid, 1);
        chk("ext_addr",     bx.cmd_addr, 16'h7B04);
        chk("ext_code",     bx.cmd_code, 8'h08);
        chk("ext_err_addr", bx.err_addr, 0);
        chk("std_err_addr", bus.err_addr, 1);
        chk("std_err_cmd",  bus.err_cmd, 0);
        tick();

        // Backpressure and overrun.
        bus.cmd_ready = 1'b0;
        send_frame(32'h20DF10EF);
        tick();
        chk("hold_valid", bus.cmd_valid, 1);
        send_frame(32'h807FA25D);           // arrives in CHECK: dropped
        chk("ovr_set",    bus.overrun, 1);
        chk("hold_addr",  bus.cmd_addr, 16'h0004);
        chk("hold_code",  bus.cmd_code, 8'h08);
        send_rpt();                         // arrives in OUT: dropped
        tick(3);
        chk("hold_valid2", bus.cmd_valid, 1);
        chk("hold_addr2",  bus.cmd_addr, 16'h0004);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", bus.overrun, 0);
        bus.ovr_clr = 1'b1;
        send_frame(32'h807FA25D);           // drop and clear together
        bus.ovr_clr = 1'b0;
        chk("ovr_wins", bus.overrun, 1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr2", bus.overrun, 0);
        bus.cmd_ready = 1'b1;
        send_frame(32'h807FA25D);           // handshake cycle accepts this frame
        chk("hs_take_ovr",   bus.overrun, 0);
        chk("hs_take_valid", bus.cmd_valid, 0);
        tick();
        chk("hs_take_valid2", bus.cmd_valid, 1);
        chk("hs_take_addr",   bus.cmd_addr, 16'h0001);
        chk("hs_take_code",   bus.cmd_code, 8'h45);
        tick();

        // Reset while in CHECK.
        send_frame(32'h20DF10EF);
        tick();
        chk("pre_rst_valid", bus.cmd_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", bus.cmd_valid, 0);
        chk("mid_rst_addr",  bus.cmd_addr, 0);
        chk("mid_rst_code",  bus.cmd_code, 0);
        chk("mid_rst_rpt",   bus.rpt_count, 0);
        chk("mid_rst_ovr",   bus.overrun, 0);
        send_rpt();                         // window closed by reset
        chk("rst_rpt_ignored", bus.cmd_valid, 0);
        send_frame(32'h20DF10EF);
        tick();
        chk("post_rst_valid", bus.cmd_valid, 1);
        chk("post_rst_addr",  bus.cmd_addr, 16'h0004);
        chk("post_rst_code",  bus.cmd_code, 8'h08);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nec_frame_checker.md
Name: nec_frame_checker

Overview:
- Sits directly downstream of the NEC IR bit decoder.
- Consumes each raw 32-bit frame, bit-reverses it into NEC byte order, and checks the address/~address and command/~command pairs.
- Tracks NEC repeat codes against a timeout window and presents validated commands to the host logic through a single-entry valid/ready output register.
- Runs on the decoder's clock domain (20 MHz nominal).

Parameters:
- EXT_ADDR_EN, 0: 1 = extended NEC (16-bit address, no address inverse check); 0 = standard 8-bit address with inverse check.
- REPEAT_WINDOW, 2200000: cycles after the last accepted frame or repeat during which a repeat code is honoured (110 ms at 20 MHz).
- RPT_CNT_W, 8: width of the saturating repeat counter.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_data  in  32  raw frame from the decoder; bit 31 = first bit received.
- frame_valid  in  1  one-cycle pulse; frame_data is valid this cycle.
- repeat_seen  in  1  one-cycle pulse; decoder detected a repeat code (9 ms + 2.25 ms + burst).
- cmd_ready  in  1  consumer accepts the output when high with cmd_valid.
- ovr_clr  in  1  clears the sticky overrun flag.
- cmd_valid  out  1  output record valid.
- cmd_addr  out  16  address; upper byte is 0 when EXT_ADDR_EN=0.
- cmd_code  out  8  command byte.
- cmd_repeat  out  1  record originates from a repeat code.
- rpt_count  out  RPT_CNT_W  repeats since the last full frame; saturates at all-ones.
- err_addr  out  1  one-cycle pulse: address inverse mismatch.
- err_cmd  out  1  one-cycle pulse: command inverse mismatch.
- overrun  out  1  sticky: event dropped because the output was full.

Behaviour:
- Reset: cmd_valid=0, cmd_addr=0, cmd_code=0, cmd_repeat=0, rpt_count=0, err_addr=0, err_cmd=0, overrun=0, repeat window closed, FSM=IDLE. Reset mid-operation discards any captured frame and any pending output.
- Byte extraction: byte k, bit i = frame_data[31-(8k+i)]; B0=addr, B1=~addr (or addr high byte when extended), B2=cmd, B3=~cmd.
- FSM states:
  - IDLE → CAPTURE on frame_valid (frame registered).
  - CAPTURE → CHECK (compare).
  - CHECK → OUT if checks pass; CHECK → IDLE with error pulse if they fail.
  - OUT → IDLE when cmd_valid && cmd_ready.
- repeat_seen is handled in IDLE only: if the window is open, load the last good addr/code with cmd_repeat=1 and go to OUT. If the window is closed, ignore it.
- Latency: frame_valid at cycle N → cmd_valid at N+2. repeat_seen at N → cmd_valid at N+1.
- Error reporting: err_cmd is checked always; err_addr only when EXT_ADDR_EN=0. If both fail, both pulse in the same cycle. A failed frame does not update the last good addr/code and does not touch the window.
- Accepted full frame: rpt_count←0, window counter←REPEAT_WINDOW.
- Accepted repeat: rpt_count+1 (saturating), window reloaded.
- Window counter decrements each cycle, clamps at 0; 0 means closed.
- Output hold: cmd_* outputs stay stable while cmd_valid=1 and cmd_ready=0.
- Overrun: frame_valid or repeat_seen arriving in any state other than IDLE is dropped and sets overrun. Only the cycle of the cmd_ready handshake accepts new input: the OUT→IDLE transition and new capture occur in the same cycle.
- ovr_clr clears overrun; a simultaneous overrun event wins (flag stays 1).
- frame_valid and repeat_seen together in IDLE: frame_valid wins; repeat_seen is ignored without an overrun.

Decomposition:
- Package nec_pkg: FSM state enum (IDLE, CAPTURE, CHECK, OUT), byte offset constants, default REPEAT_WINDOW, and a bit-reverse-byte function.
- One sub-module, nec_repeat_timer: loadable down-counter with an open/closed flag; instantiated once.

Test Plan:
- frame_data=0x20DF10EF pulse, cmd_ready=1 → cmd_valid at N+2, cmd_addr=0x0004, cmd_code=0x08, cmd_repeat=0, no error pulses.
- frame_data=0x20DF10EE → err_cmd pulses once, cmd_valid stays 0; a following repeat_seen yields no output if no prior good frame exists.
- Valid frame 0x20DF10EF, then repeat_seen 1000 cycles later → cmd_repeat=1, addr=0x04, code=0x08, rpt_count=1. A repeat arriving REPEAT_WINDOW+1 cycles after the last accepted event → ignored.
- EXT_ADDR_EN=1, frame_data=0x20DE10EF → cmd_addr=0x7B04, no err_addr.
- Hold cmd_ready=0 after a valid frame, send a second frame → first record held unchanged, overrun=1. Raise ovr_clr → overrun=0.
- Assert rst while in CHECK → next cycle all outputs 0, FSM idle; the next valid frame decodes normally.
